regfile_read_arbiter: RTL and testbench

REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

---
 rtl/regfile_read_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_read_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter: four requesters share one register-file read port.
// Latency: grant the cycle after req is sampled, rd_valid one cycle later; 3 cycles per read.
// Backpressure: none; requesters hold req level-high until they see rd_valid.
module regfile_read_arbiter #(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [19:0] req_addr,
    input  logic [31:0] rf_data,
    output logic [4:0]  rf_addr,
    output logic [3:0]  grant,
    output logic [3:0]  rd_valid,
    output logic [31:0] rd_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [1:0]  win;
    logic [1:0]  win_nxt;
    logic        win_found;
    logic [1:0]  scan_idx;
    logic [4:0]  addr_arr [4];

    // Unpack the per-requester address fields
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_arr[i] = req_addr[5*i +: 5];
        end
    end

    // Round-robin scan starting at ptr; descending loop lets the lowest offset win
    always_comb begin
        win_found = 1'b0;
        win_nxt   = ptr;
        scan_idx  = ptr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr + 2'(k);
            if (req[scan_idx]) begin
                win_found = 1'b1;
                win_nxt   = scan_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: ISSUE and DONE each last exactly one cycle, req only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = win_found ? ISSUE : IDLE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and the latched winner, so reset clears them at once
    always_comb begin
        grant    = 4'b0000;
        rd_valid = 4'b0000;
        busy     = (state != IDLE);
        case (state)
            ISSUE:   grant    = 4'b0001 << win;
            DONE:    rd_valid = 4'b0001 << win;
            default: ;
        endcase
    end

    // Datapath: latch winner and address on grant, capture read data at end of ISSUE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_addr <= 5'd0;
            rd_data <= 32'h0;
            ptr     <= 2'd0;
            win     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        rf_addr <= addr_arr[win_nxt];
                        win     <= win_nxt;
                    end
                end
                ISSUE: begin
                    rd_data <= (ZERO_REG && (rf_addr == 5'd0)) ? 32'h0 : rf_data;
                    ptr     <= win + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus a per-cycle transaction model.
// Latency: model expects grant one cycle after sampling, rd_valid the next, idle after that.
// Backpressure: none; requesters drive req levels from the stimulus process.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [19:0] req_addr = 20'h0;

    logic [31:0] rf_mem [32];

    logic [31:0] rf_data_z, rf_data_nz;
    logic [4:0]  rf_addr_z, rf_addr_nz;
    logic [3:0]  grant_z, grant_nz, rd_valid_z, rd_valid_nz;
    logic [31:0] rd_data_z, rd_data_nz;
    logic        busy_z, busy_nz;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign rf_data_z  = rf_mem[rf_addr_z];
    assign rf_data_nz = rf_mem[rf_addr_nz];

    regfile_read_arbiter #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .rf_data(rf_data_z),
        .rf_addr(rf_addr_z), .grant(grant_z), .rd_valid(rd_valid_z), .rd_data(rd_data_z), .busy(busy_z)
    );

    regfile_read_arbiter #(.ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .rf_data(rf_data_nz),
        .rf_addr(rf_addr_nz), .grant(grant_nz), .rd_valid(rd_valid_nz), .rd_data(rd_data_nz), .busy(busy_nz)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    // Transaction model: a read occupies the port for two cycles after it is accepted
    int          m_left;
    int          m_win;
    int          m_ptr;
    logic [4:0]  m_addr;
    logic [31:0] m_data_z, m_data_nz;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0; m_win = 0; m_ptr = 0; m_addr = 5'd0;
            m_data_z = 32'h0; m_data_nz = 32'h0;
        end else if (m_left == 0) begin
            if (req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (req[(m_ptr + k) % 4]) begin
                        m_win = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_addr = req_addr[5*m_win +: 5];
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_data_nz = rf_mem[m_addr];
            m_data_z  = (m_addr == 5'd0) ? 32'h0 : rf_mem[m_addr];
            m_ptr     = (m_win + 1) % 4;
            m_left    = 1;
        end else begin
            m_left = 0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        chk("grant",       {28'h0, grant_z},    {28'h0, (m_left == 2) ? oh(m_win) : 4'b0000});
        chk("rd_valid",    {28'h0, rd_valid_z}, {28'h0, (m_left == 1) ? oh(m_win) : 4'b0000});
        chk("busy",        {31'h0, busy_z},     {31'h0, m_left != 0});
        chk("rf_addr",     {27'h0, rf_addr_z},  {27'h0, m_addr});
        chk("rd_data_z",   rd_data_z,           m_data_z);
        chk("rd_data_nz",  rd_data_nz,          m_data_nz);
        chk("grant_nz",    {28'h0, grant_nz},   {28'h0, grant_z});
        chk("rd_valid_nz", {28'h0, rd_valid_nz},{28'h0, rd_valid_z});
    end

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[5*i +: 5] = a;
    endtask

    // Waits up to 20 cycles for a grant; returns winner index or -1 on timeout
    task automatic wait_grant(output int w, output int t);
        w = -1;
        t = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (grant_z != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (grant_z[i]) w = i;
                t = cyc;
                break;
            end
        end
        if (w < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant expected one within 20 cycles");
        end
    endtask

    int w, t, t_prev;

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA5000000 + 32'(i * 32'h00010101);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant",    {28'h0, grant_z},    32'h0);
        chk("rst_rd_valid", {28'h0, rd_valid_z}, 32'h0);
        chk("rst_rd_data",  rd_data_z,           32'h0);
        chk("rst_rf_addr",  {27'h0, rf_addr_z},  32'h0);
        chk("rst_busy",     {31'h0, busy_z},     32'h0);
        reset_n = 1'b1;

        // Single read from requester 1 of register 5
        rf_mem[5] = 32'hDEADBEEF;
        set_addr(1, 5'd5);
        req = 4'b0010;
        wait_grant(w, t);
        chk("r1_grant", {28'h0, grant_z}, 32'h2);
        chk("r1_busy",  {31'h0, busy_z},  32'h1);
        @(posedge clk); #1;
        chk("r1_grant_clr", {28'h0, grant_z},    32'h0);
        chk("r1_rd_valid",  {28'h0, rd_valid_z}, 32'h2);
        chk("r1_rd_data",   rd_data_z,           32'hDEADBEEF);
        chk("r1_busy2",     {31'h0, busy_z},     32'h1);
        req = 4'b0000;
        @(posedge clk); #1;
        chk("r1_rd_valid_clr", {28'h0, rd_valid_z}, 32'h0);
        chk("r1_idle",         {31'h0, busy_z},     32'h0);
        repeat (2) @(posedge clk); #1;
        chk("idle_no_grant", {28'h0, grant_z}, 32'h0);

        // Reset during ISSUE of requester 2
        set_addr(2, 5'd3);
        req = 4'b0100;
        wait_grant(w, t);
        chk("r2_grant", {28'h0, grant_z}, 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant",    {28'h0, grant_z},    32'h0);
        chk("arst_rd_valid", {28'h0, rd_valid_z}, 32'h0);
        chk("arst_rd_data",  rd_data_z,           32'h0);
        chk("arst_rf_addr",  {27'h0, rf_addr_z},  32'h0);
        chk("arst_busy",     {31'h0, busy_z},     32'h0);
        for (int i = 0; i < 4; i++) set_addr(i, 5'(10 + i));
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Rotation with all four requesting; each drops for one cycle after rd_valid
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_grant(w, t);
            chk("rot_grant", {28'h0, grant_z}, {28'h0, oh(n % 4)});
            if (n > 0) chk("rot_spacing", 32'(t - t_prev), 32'd3);
            t_prev = t;
            @(posedge clk); #1;
            chk("rot_rd_valid", {28'h0, rd_valid_z}, {28'h0, oh(n % 4)});
            chk("rot_rd_data",  rd_data_z,           rf_mem[10 + (n % 4)]);
            if (w >= 0) req[w] = 1'b0;
            @(posedge clk); #1;
            if (w >= 0) req[w] = 1'b1;
        end
        req = 4'b0000;
        repeat (4) @(posedge clk);
        #1;

        // Register 0 reads as zero only when ZERO_REG is set
        rf_mem[0] = 32'hFFFFFFFF;
        set_addr(0, 5'd0);
        req = 4'b0001;
        wait_grant(w, t);
        chk("z_grant", {28'h0, grant_z}, 32'h1);
        @(posedge clk); #1;
        chk("z_rd_data_zero", rd_data_z,  32'h0);
        chk("z_rd_data_raw",  rd_data_nz, 32'hFFFFFFFF);
        req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;

        // Address change and req drop during ISSUE do not affect the in-flight read
        rf_mem[7] = 32'h12345678;
        rf_mem[9] = 32'h0BADF00D;
        set_addr(2, 5'd7);
        req = 4'b0100;
        wait_grant(w, t);
        chk("lat_grant",   {28'h0, grant_z},   32'h4);
        chk("lat_rf_addr", {27'h0, rf_addr_z}, 32'd7);
        set_addr(2, 5'd9);
        req = 4'b0000;
        @(posedge clk); #1;
        chk("lat_rd_valid", {28'h0, rd_valid_z}, 32'h4);
        chk("lat_rd_data",  rd_data_z,           32'h12345678);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_rd_data", rd_data_z, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
